// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: op encodings and decode
// helpers shared by the pipelined add/sub slice.
package pipelined_addsub_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDS = 2'b10;
  localparam logic [1:0] OP_SUBS = 2'b11;

  function automatic logic is_sub(
    input logic [1:0] op
  );
    return (op == OP_SUB) || (op == OP_SUBS);
  endfunction

  function automatic logic is_sat(
    input logic [1:0] op
  );
    return (op == OP_ADDS) || (op == OP_SUBS);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand-in / result-out
// valid/ready bundle; slave = adder, master = user.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
) ();

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] d0_i;
  logic [WIDTH-1:0] d1_i;
  logic [1:0]       op_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] d_o;
  logic             carry_o;
  logic             ovf_o;
  logic             zero_o;

  modport slave (
    input  valid_i, d0_i, d1_i, op_i, ready_i,
    output ready_o, valid_o, d_o,
    output carry_o, ovf_o, zero_o
  );

  modport master (
    output valid_i, d0_i, d1_i, op_i, ready_i,
    input  ready_o, valid_o, d_o,
    input  carry_o, ovf_o, zero_o
  );

endinterface

// File: rtl/pipelined_addsub_slice.sv
// pipelined_addsub_slice: W-bit combinational adder
// a_i+b_i+c_i -> s_o with carry-out c_o.
module pipelined_addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  assign {c_o, s_o} = {1'b0, a_i}
                    + {1'b0, b_i}
                    + {{W{1'b0}}, c_i};

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep carry-chained signed
// add/sub, wrap or saturate; ports clk, reset_n, bus.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input logic               clk,
  input logic               reset_n,
  pipelined_addsub_if.slave bus
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  localparam int M  = WIDTH - 1;

  typedef logic [WIDTH-1:0] word_t;

  logic                   adv;
  logic [STAGES-1:0]      v_q;
  logic [STAGES-1:0]      c_q;
  word_t [STAGES-1:0]     a_q;
  word_t [STAGES-1:0]     b_q;
  word_t [STAGES-1:0]     sum_q;
  logic [STAGES-1:0][1:0] op_q;
  logic                   ovf_q;
  logic                   zero_q;

  word_t [STAGES-1:0]     a_in;
  word_t [STAGES-1:0]     b_in;
  word_t [STAGES-1:0]     sum_in;
  word_t [STAGES-1:0]     sum_d;
  logic [STAGES-1:0][1:0] op_in;
  logic [STAGES-1:0]      cin;
  logic [STAGES-1:0]      co;
  logic [STAGES-1:0][SW-1:0] s;

  word_t raw;
  word_t res_d;
  logic  ovf_d;
  logic  unused_ok;

  assign adv = bus.ready_i | ~v_q[L];

  // Stage k sees the operands/carry that
  // stage k-1 registered; stage 0 sees the port.
  always_comb begin
    a_in[0]   = bus.d0_i;
    b_in[0]   = is_sub(bus.op_i) ? ~bus.d1_i
                                 : bus.d1_i;
    op_in[0]  = bus.op_i;
    cin[0]    = is_sub(bus.op_i);
    sum_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      op_in[k]  = op_q[k-1];
      cin[k]    = c_q[k-1];
      sum_in[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    pipelined_addsub_slice #(
      .W (SW)
    ) u_slice (
      .a_i (a_in[k][k*SW +: SW]),
      .b_i (b_in[k][k*SW +: SW]),
      .c_i (cin[k]),
      .s_o (s[k]),
      .c_o (co[k])
    );
  end

  always_comb begin
    sum_d = sum_in;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k][k*SW +: SW] = s[k];
    end
  end

  // Overflow: same-sign operands (B' after
  // inversion), result sign differs.
  always_comb begin
    raw   = sum_d[L];
    ovf_d = (a_in[L][M] == b_in[L][M])
          & (raw[M] != a_in[L][M]);
    res_d = raw;
    if (is_sat(op_in[L]) && ovf_d) begin
      res_d = a_in[L][M] ? {1'b1, {M{1'b0}}}
                         : {1'b0, {M{1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q    <= '0;
      c_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      v_q[0] <= bus.valid_i;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      a_q      <= a_in;
      b_q      <= b_in;
      op_q     <= op_in;
      c_q      <= co;
      sum_q    <= sum_d;
      sum_q[L] <= res_d;
      ovf_q    <= ovf_d;
      zero_q   <= (res_d == '0);
    end
  end

  // Last-stage operand copies and the already
  // consumed low slices are never read.
  assign unused_ok = ^{a_q, b_q, op_q};

  assign bus.ready_o = adv;
  assign bus.valid_o = v_q[L];
  assign bus.d_o     = sum_q[L];
  assign bus.carry_o = c_q[L];
  assign bus.ovf_o   = ovf_q;
  assign bus.zero_o  = zero_q;

endmodule
